// File: rtl/tag_free_list.sv
// Free pool of physical register tags: circular FIFO, one grant and two frees per cycle.
// Optional in-pool bitmap double-free detection: FREE_LIST_DOUBLE_FREE_CHECK_EN.
module tag_free_list #(
    parameter int NUM_TAGS       = 64,
    parameter int FIRST_FREE_TAG = 32,
    parameter int TW             = $clog2(NUM_TAGS),
    parameter int CW             = TW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          alloc_req,
    output logic          alloc_valid,
    output logic [TW-1:0] alloc_tag,
    input  logic [TW-1:0] free_tag_1,
    input  logic [TW-1:0] free_tag_2,
    output logic [CW-1:0] free_count,
    output logic          error
);

    localparam logic [CW-1:0] MAX_CNT  = CW'(NUM_TAGS - 1);
    localparam logic [CW-1:0] INIT_CNT = CW'(NUM_TAGS - FIRST_FREE_TAG);

    logic [TW-1:0] fifo_q [NUM_TAGS];
    logic [TW-1:0] fifo_d [NUM_TAGS];
    logic [TW-1:0] head_q, head_d;
    logic [TW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          error_q, error_d;

    logic          grant;
    logic [TW-1:0] head_tag;
    logic          v1, v2, same;
    logic          dup1, dup2;
    logic          acc1, acc2;
    logic [CW-1:0] base;
    logic          ovf;

`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
    logic [NUM_TAGS-1:0] in_pool_q, in_pool_d;
`endif

    assign head_tag    = fifo_q[head_q];
    assign alloc_valid = (count_q != '0);
    assign alloc_tag   = alloc_valid ? head_tag : '0;
    assign free_count  = count_q;
    assign error       = error_q;
    assign grant       = alloc_req && alloc_valid;

    always_comb begin
        v1   = (free_tag_1 != '0);
        same = v1 && (free_tag_2 == free_tag_1);
        v2   = (free_tag_2 != '0) && !same;
`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
        // A tag leaving the pool this cycle may legally come straight back.
        dup1 = v1 && in_pool_q[free_tag_1]
            && !(grant && head_tag == free_tag_1);
        dup2 = v2 && in_pool_q[free_tag_2]
            && !(grant && head_tag == free_tag_2);
`else
        dup1 = 1'b0;
        dup2 = 1'b0;
`endif
        base = count_q - CW'(grant);
        acc1 = v1 && !dup1 && (base < MAX_CNT);
        acc2 = v2 && !dup2 && ((base + CW'(acc1)) < MAX_CNT);
        ovf  = (v1 && !dup1 && !acc1) || (v2 && !dup2 && !acc2);
    end

    always_comb begin
        fifo_d  = fifo_q;
        head_d  = head_q + TW'(grant);
        tail_d  = tail_q + TW'(acc1) + TW'(acc2);
        count_d = base + CW'(acc1) + CW'(acc2);
        error_d = error_q || same || dup1 || dup2 || ovf;
        if (acc1)
            fifo_d[tail_q] = free_tag_1;
        if (acc2)
            fifo_d[tail_q + TW'(acc1)] = free_tag_2;
    end

`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
    always_comb begin
        in_pool_d = in_pool_q;
        if (grant)
            in_pool_d[head_tag] = 1'b0;
        if (acc1)
            in_pool_d[free_tag_1] = 1'b1;
        if (acc2)
            in_pool_d[free_tag_2] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_TAGS; i++)
                in_pool_q[i] <= (i >= FIRST_FREE_TAG);
        end else begin
            in_pool_q <= in_pool_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_TAGS; i++)
                fifo_q[i] <= (i < NUM_TAGS - FIRST_FREE_TAG)
                    ? TW'(FIRST_FREE_TAG + i) : '0;
            head_q  <= '0;
            tail_q  <= TW'(NUM_TAGS - FIRST_FREE_TAG);
            count_q <= INIT_CNT;
            error_q <= 1'b0;
        end else begin
            fifo_q  <= fifo_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            error_q <= error_d;
        end
    end

endmodule
